// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) multiplier with optional multiply-accumulate.
// MSB-first Horner over D-bit multiplier digits, with iterative overflow reduction.
module gf2m_digit_mul #(
    parameter int unsigned M = 144,
    parameter int unsigned D = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic         mac,
    input  logic [M-1:0] multiplicand,
    input  logic [M-1:0] multiplier,
    input  logic [M-1:0] mod,
    input  logic [M-1:0] addend,
    output logic [M-1:0] result,
    output logic         done,
    output logic         busy
);

    localparam int unsigned ND = M / D;
    localparam int unsigned JW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, STEP, REDUCE} state_t;

    // Carry-less product of an M-bit operand and a D-bit operand.
    function automatic logic [M+D-1:0] clmul_md(input logic [M-1:0] x, input logic [D-1:0] y);
        logic [M+D-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < D; i++) begin
            if (y[i]) p = p ^ ({{D{1'b0}}, x} << i);
        end
        return p;
    endfunction

    state_t         state, state_n;
    logic [JW-1:0]  j, j_n;
    logic [M-1:0]   a_q, b_q, f_q, c_q;
    logic           mac_q;
    logic [M-1:0]   acc, acc_n;
    logic [M+D-1:0] t, t_n;
    logic [M-1:0]   result_n;
    logic           done_n, busy_n, latch;

    logic [D-1:0]   digit;
    logic [D-1:0]   h;
    logic [M-1:0]   addend_term;
    logic [M+D-1:0] step_prod, red_prod;

    assign digit       = b_q[j*D +: D];
    assign h           = t[M+D-1:M];
    assign addend_term = mac_q ? c_q : '0;
    assign step_prod   = {acc, {D{1'b0}}} ^ clmul_md(a_q, digit);
    assign red_prod    = {{D{1'b0}}, t[M-1:0]} ^ clmul_md(f_q, h);

    always_comb begin
        state_n  = state;
        j_n      = j;
        acc_n    = acc;
        t_n      = t;
        result_n = result;
        done_n   = 1'b0;
        busy_n   = busy;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    acc_n   = '0;
                    j_n     = JW'(ND - 1);
                    busy_n  = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (digit != '0) begin
                    state_n = STEP;
                end else if (j != '0) begin
                    j_n = j - JW'(1);
                end else begin
                    result_n = addend_term;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            STEP: begin
                t_n     = step_prod;
                state_n = REDUCE;
            end
            REDUCE: begin
                // Each pass strictly lowers the overflow degree, so this loop terminates.
                if (h != '0) begin
                    t_n = red_prod;
                end else if (j != '0) begin
                    acc_n   = t[M-1:0];
                    j_n     = j - JW'(1);
                    state_n = STEP;
                end else begin
                    result_n = t[M-1:0] ^ addend_term;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            j      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            c_q    <= '0;
            mac_q  <= 1'b0;
            acc    <= '0;
            t      <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            j      <= j_n;
            acc    <= acc_n;
            t      <= t_n;
            result <= result_n;
            done   <= done_n;
            busy   <= busy_n;
            if (latch) begin
                a_q   <= multiplicand;
                b_q   <= multiplier;
                f_q   <= mod;
                c_q   <= addend;
                mac_q <= mac;
            end
        end
    end

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Self-checking bench for gf2m_digit_mul: directed cases plus randomized
// operands checked against a bit-serial polynomial reference and a latency model.
module tb_gf2m_digit_mul;

    localparam int unsigned M  = 144;
    localparam int unsigned D  = 16;
    localparam int unsigned ND = M / D;
    localparam int          LIMIT = 400;

    logic         clk;
    logic         rst_b;
    logic         start;
    logic         mac;
    logic [M-1:0] multiplicand, multiplier, mod, addend;
    logic [M-1:0] result;
    logic         done, busy;

    int tests = 0;
    int fails = 0;

    gf2m_digit_mul #(.M(M), .D(D)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .mac(mac),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .mod(mod), .addend(addend),
        .result(result), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] rand_vec();
        logic [M+31:0] v;
        v = '0;
        for (int w = 0; w < int'((M + 31) / 32); w++) v[w*32 +: 32] = $urandom;
        return v[M-1:0];
    endfunction

    // Plain polynomial product over GF(2).
    function automatic logic [2*M-1:0] clmul_w(input logic [2*M-1:0] x, input logic [2*M-1:0] y);
        logic [2*M-1:0] p;
        p = '0;
        for (int i = 0; i < int'(M); i++) if (y[i]) p = p ^ (x << i);
        return p;
    endfunction

    // Full product, then long division by f one bit at a time from the top.
    function automatic logic [M-1:0] golden(input logic m, input logic [M-1:0] a, b, f, c);
        logic [2*M-1:0] p, fw;
        p  = clmul_w({{M{1'b0}}, a}, {{M{1'b0}}, b});
        fw = {{M{1'b0}}, f};
        fw[M] = 1'b1;
        for (int i = 2*M - 2; i >= int'(M); i--) if (p[i]) p = p ^ (fw << (i - M));
        return p[M-1:0] ^ (m ? c : {M{1'b0}});
    endfunction

    // Cycle count from accept edge to commit edge, counting overflow folds per digit.
    function automatic int predict(input logic [M-1:0] a, b, f);
        int k, cyc, passes;
        logic [2*M-1:0] acc, tt, hh;
        k = -1;
        for (int jj = ND - 1; jj >= 0; jj--) begin
            if (b[jj*D +: D] != '0) begin
                k = jj;
                break;
            end
        end
        if (k < 0) return ND;
        cyc = ND - k;
        acc = '0;
        for (int jj = k; jj >= 0; jj--) begin
            tt = (acc << D) ^ clmul_w({{M{1'b0}}, a}, {{(2*M-D){1'b0}}, b[jj*D +: D]});
            passes = 0;
            while ((tt >> M) != '0) begin
                hh = tt >> M;
                tt = (tt & ~({2*M{1'b1}} << M)) ^ clmul_w(hh, {{M{1'b0}}, f});
                passes++;
            end
            cyc += 2 + passes;
            acc = tt;
        end
        return cyc;
    endfunction

    task automatic run_op(input logic m, input logic [M-1:0] a, b, f, c, input bit noise,
                          output int lat, output int busy_cnt, output int dones);
        mac = m; multiplicand = a; multiplier = b; mod = f; addend = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        dones = 0;
        while (lat < LIMIT) begin
            if (noise) begin
                start = 1'b1; mac = ~mac;
                multiplicand = rand_vec(); multiplier = rand_vec();
                mod = rand_vec(); addend = rand_vec();
            end
            @(posedge clk); #1;
            lat++;
            if (done) begin
                dones++;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
    endtask

    logic [M-1:0] a, b, c, f, exp_v, top;
    logic         m;
    int lat, bc, dn, pc, extra;

    initial begin
        rst_b = 1'b0; start = 1'b0; mac = 1'b0;
        multiplicand = '0; multiplier = '0; mod = '0; addend = '0;
        top = '0; top[M-1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, '0);
        check("reset_done", M'(done), '0);
        check("reset_busy", M'(busy), '0);
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk); #1;

        // a=1, b=1: single digit, no overflow
        run_op(1'b0, M'(1), M'(1), M'(43), '0, 1'b0, lat, bc, dn);
        check("t1_result", result, M'(1));
        check("t1_latency", M'(lat), M'(11));
        check("t1_busy_cycles", M'(bc), M'(11));
        @(posedge clk); #1;
        check("t1_done_width", M'(done), '0);

        // a=x^143, b=x: one reduction pass
        run_op(1'b0, top, M'(2), M'(43), '0, 1'b0, lat, bc, dn);
        check("t2_result", result, M'(43));
        check("t2_latency", M'(lat), M'(12));

        // b=0 in MAC mode returns the addend after the scan only
        run_op(1'b1, rand_vec(), '0, M'(43), M'(16'hABCD), 1'b0, lat, bc, dn);
        check("t3_result", result, M'(16'hABCD));
        check("t3_latency", M'(lat), M'(9));

        // Asynchronous reset while in REDUCE
        mac = 1'b0; multiplicand = top; multiplier = M'(2); mod = M'(43); addend = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("rst_busy_before", M'(busy), M'(1));
        rst_b = 1'b0;
        #1;
        check("rst_result", result, '0);
        check("rst_done", M'(done), '0);
        check("rst_busy", M'(busy), '0);
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, M'(3), M'(5), M'(43), '0, 1'b0, lat, bc, dn);
        check("post_rst_result", result, M'(15));
        check("post_rst_latency", M'(lat), M'(11));

        // start hammered with fresh operands during an operation
        a = rand_vec(); b = rand_vec(); c = rand_vec(); f = '1;
        exp_v = golden(1'b1, a, b, f, c);
        pc = predict(a, b, f);
        run_op(1'b1, a, b, f, c, 1'b1, lat, bc, dn);
        check("noise_result", result, exp_v);
        check("noise_latency", M'(lat), M'(pc));
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("noise_done_count", M'(dn + extra), M'(1));
        check("noise_idle_busy", M'(busy), '0);

        // Randomized operands, dense and random field polynomials, both modes
        for (int n = 0; n < 300; n++) begin
            m = n[0];
            a = rand_vec(); b = rand_vec(); c = rand_vec();
            for (int jj = 0; jj < int'(ND); jj++)
                if ($urandom_range(3) == 0) b[jj*D +: D] = '0;
            f = (n % 4 < 2) ? '1 : rand_vec();
            exp_v = golden(m, a, b, f, c);
            pc = predict(a, b, f);
            run_op(m, a, b, f, c, 1'b0, lat, bc, dn);
            check("rand_result", result, exp_v);
            check("rand_latency", M'(lat), M'(pc));
            check("rand_bound", M'(lat <= 171), M'(1));
            check("rand_done", M'(dn), M'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
